// File: rtl/board_in_cond_if.sv
// Pad-side and SoC-side signals of the board input conditioner.
// BOARD_IN_GLITCH_CNT_EN adds the 16-bit glitch_cnt status output.
interface board_in_cond_if;
  logic sw_upgrade_b_raw;
  logic btn_rst_b_raw;
  logic uart_rx_raw;
  logic sw_upgrade_b;
  logic sw_event;
  logic uart_rx;
  logic rstb_soc;
`ifdef BOARD_IN_GLITCH_CNT_EN
  logic [15:0] glitch_cnt;

  modport master (
    output sw_upgrade_b_raw, btn_rst_b_raw, uart_rx_raw,
    input  sw_upgrade_b, sw_event, uart_rx, rstb_soc, glitch_cnt
  );

  modport slave (
    input  sw_upgrade_b_raw, btn_rst_b_raw, uart_rx_raw,
    output sw_upgrade_b, sw_event, uart_rx, rstb_soc, glitch_cnt
  );
`else
  modport master (
    output sw_upgrade_b_raw, btn_rst_b_raw, uart_rx_raw,
    input  sw_upgrade_b, sw_event, uart_rx, rstb_soc
  );

  modport slave (
    input  sw_upgrade_b_raw, btn_rst_b_raw, uart_rx_raw,
    output sw_upgrade_b, sw_event, uart_rx, rstb_soc
  );
`endif
endinterface

// File: rtl/board_in_cond.sv
// Board input conditioner: pad synchronisers, switch/button debounce, RX majority
// filter and stretched SoC reset. Optional macro BOARD_IN_GLITCH_CNT_EN adds glitch_cnt.

module board_in_cond_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rstb_in,
  input  logic sync_i,
  output logic out_o,
  output logic flip_o,
  output logic abort_o
);
  typedef enum logic {STABLE, CHANGING} db_state_e;

  localparam logic [31:0] LAST = 32'(DEBOUNCE_CYCLES - 1);

  db_state_e   state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        out_q, out_d;

  always_ff @(posedge clk or negedge rstb_in) begin
    if (!rstb_in) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    flip_o  = 1'b0;
    abort_o = 1'b0;
    case (state_q)
      STABLE: begin
        if (sync_i != out_q) begin
          state_d = CHANGING;
          cnt_d   = 32'd1;
        end
      end
      CHANGING: begin
        // Returning to the current level always wins over reaching the count.
        if (sync_i == out_q) begin
          state_d = STABLE;
          cnt_d   = '0;
          abort_o = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = STABLE;
          cnt_d   = '0;
          out_d   = sync_i;
          flip_o  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    endcase
  end

  assign out_o = out_q;
endmodule

module board_in_cond #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned POR_CYCLES      = 1024
) (
  input  logic             clk,
  input  logic             rstb_in,
  board_in_cond_if.slave   io
);
  typedef enum logic [1:0] {HOLD, COUNT, RUN} rst_state_e;

  localparam int unsigned PW = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
  localparam logic [PW-1:0] PLAST = PW'(POR_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sw_sync_q, btn_sync_q, rx_sync_q;
  logic [1:0]             rx_samp_q;
  logic                   uart_rx_q, uart_rx_d;
  logic                   sw_event_q;
  logic                   sw_sync, btn_sync, rx_sync;
  logic                   sw_db, btn_db, sw_flip, unused_btn_flip;
  logic                   abort_sw, abort_btn;

  rst_state_e             rst_state_q, rst_state_d;
  logic [PW-1:0]          pcnt_q, pcnt_d;
  logic                   rstb_soc_q, rstb_soc_d;

  assign sw_sync  = sw_sync_q[SYNC_STAGES-1];
  assign btn_sync = btn_sync_q[SYNC_STAGES-1];
  assign rx_sync  = rx_sync_q[SYNC_STAGES-1];

  // Two of the newest three RX samples decide, so a one-cycle glitch is dropped.
  assign uart_rx_d = (rx_samp_q[1] & rx_samp_q[0]) | (rx_samp_q[1] & rx_sync) |
                     (rx_samp_q[0] & rx_sync);

  always_ff @(posedge clk or negedge rstb_in) begin
    if (!rstb_in) begin
      sw_sync_q  <= '1;
      btn_sync_q <= '1;
      rx_sync_q  <= '1;
      rx_samp_q  <= 2'b11;
      uart_rx_q  <= 1'b1;
      sw_event_q <= 1'b0;
    end else begin
      sw_sync_q  <= {sw_sync_q[SYNC_STAGES-2:0], io.sw_upgrade_b_raw};
      btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], io.btn_rst_b_raw};
      rx_sync_q  <= {rx_sync_q[SYNC_STAGES-2:0], io.uart_rx_raw};
      rx_samp_q  <= {rx_samp_q[0], rx_sync};
      uart_rx_q  <= uart_rx_d;
      sw_event_q <= sw_flip;
    end
  end

  board_in_cond_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw (
    .clk     (clk),
    .rstb_in (rstb_in),
    .sync_i  (sw_sync),
    .out_o   (sw_db),
    .flip_o  (sw_flip),
    .abort_o (abort_sw)
  );

  board_in_cond_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
    .clk     (clk),
    .rstb_in (rstb_in),
    .sync_i  (btn_sync),
    .out_o   (btn_db),
    .flip_o  (unused_btn_flip),
    .abort_o (abort_btn)
  );

  always_ff @(posedge clk or negedge rstb_in) begin
    if (!rstb_in) begin
      rst_state_q <= HOLD;
      pcnt_q      <= '0;
      rstb_soc_q  <= 1'b0;
    end else begin
      rst_state_q <= rst_state_d;
      pcnt_q      <= pcnt_d;
      rstb_soc_q  <= rstb_soc_d;
    end
  end

  always_comb begin
    rst_state_d = rst_state_q;
    pcnt_d      = pcnt_q;
    rstb_soc_d  = rstb_soc_q;
    case (rst_state_q)
      HOLD: begin
        rstb_soc_d = 1'b0;
        if (btn_db) begin
          rst_state_d = COUNT;
          pcnt_d      = '0;
        end
      end
      COUNT: begin
        if (!btn_db) begin
          rst_state_d = HOLD;
          pcnt_d      = '0;
          rstb_soc_d  = 1'b0;
        end else if (pcnt_q == PLAST) begin
          rst_state_d = RUN;
          rstb_soc_d  = 1'b1;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!btn_db) begin
          rst_state_d = HOLD;
          pcnt_d      = '0;
          rstb_soc_d  = 1'b0;
        end else begin
          rstb_soc_d = 1'b1;
        end
      end
      default: begin
        rst_state_d = HOLD;
        pcnt_d      = '0;
        rstb_soc_d  = 1'b0;
      end
    endcase
  end

`ifdef BOARD_IN_GLITCH_CNT_EN
  logic [15:0] glitch_cnt_q, glitch_cnt_d;
  logic [16:0] glitch_sum;

  always_comb begin
    glitch_sum   = {1'b0, glitch_cnt_q} + 17'(abort_sw) + 17'(abort_btn);
    glitch_cnt_d = glitch_sum[16] ? 16'hFFFF : glitch_sum[15:0];
  end

  always_ff @(posedge clk or negedge rstb_in) begin
    if (!rstb_in) glitch_cnt_q <= '0;
    else          glitch_cnt_q <= glitch_cnt_d;
  end

  assign io.glitch_cnt = glitch_cnt_q;
`else
  logic unused_abort;
  assign unused_abort = abort_sw | abort_btn;
`endif

  assign io.sw_upgrade_b = sw_db;
  assign io.sw_event     = sw_event_q;
  assign io.uart_rx      = uart_rx_q;
  assign io.rstb_soc     = rstb_soc_q;
endmodule

// File: tb/tb_board_in_cond.sv
// Bench for board_in_cond: history-window model of the conditioner compared every
// cycle, plus directed literal checks. Honours BOARD_IN_GLITCH_CNT_EN.
module tb_board_in_cond;
  localparam int S    = 2;
  localparam int D    = 8;
  localparam int P    = 16;
  localparam int MAXN = 4096;

  logic clk = 1'b0;
  logic rstb_in = 1'b0;
  int   n = 0;
  int   compared = 0;
  int   mismatched = 0;

  board_in_cond_if io();

  board_in_cond #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .POR_CYCLES(P)) dut (
    .clk     (clk),
    .rstb_in (rstb_in),
    .io      (io)
  );

  always #5 clk = ~clk;

  // Raw pad values as seen at each edge since reset release (0 sw, 1 btn, 2 rx)
  logic rawh [0:2][0:MAXN-1];
  logic mdb  [0:1][0:MAXN-1];
  logic mev  [0:MAXN-1];
  logic mrx  [0:MAXN-1];
  logic mrstb[0:MAXN-1];
  int   mgl  [0:MAXN-1];
  logic cur_v, all_v;
  int   ab_v;

  function automatic logic syncv(int ch, int t);
    if (t - S < 1) return 1'b1;
    return rawh[ch][t - S];
  endfunction

  function automatic logic maj(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
    end
  endfunction

  // Model: a debounced level flips once the last D synced samples all differ from it;
  // rstb_soc is high once the debounced button has been released for P+1 edges.
  always @(posedge clk or negedge rstb_in) begin
    if (!rstb_in) begin
      n = 0;
      mdb[0][0] = 1'b1;
      mdb[1][0] = 1'b1;
      mev[0]    = 1'b0;
      mrx[0]    = 1'b1;
      mrstb[0]  = 1'b0;
      mgl[0]    = 0;
    end else if (n < MAXN - 1) begin
      n = n + 1;
      rawh[0][n] = io.sw_upgrade_b_raw;
      rawh[1][n] = io.btn_rst_b_raw;
      rawh[2][n] = io.uart_rx_raw;
      ab_v = 0;
      for (int ch = 0; ch < 2; ch++) begin
        cur_v = mdb[ch][n-1];
        all_v = 1'b1;
        for (int i = 0; i < D; i++)
          if (syncv(ch, n - i) == cur_v) all_v = 1'b0;
        mdb[ch][n] = all_v ? ~cur_v : cur_v;
        if (syncv(ch, n) == cur_v && syncv(ch, n - 1) != cur_v) ab_v++;
      end
      mev[n] = (mdb[0][n] != mdb[0][n-1]);
      mrx[n] = maj(syncv(2, n - 2), syncv(2, n - 1), syncv(2, n));
      all_v = 1'b1;
      for (int k = n - P - 1; k <= n - 1; k++)
        if (k < 0 || !mdb[1][k]) all_v = 1'b0;
      mrstb[n] = all_v;
      mgl[n] = (mgl[n-1] + ab_v > 65535) ? 65535 : mgl[n-1] + ab_v;
    end
  end

  always @(negedge clk) begin
    check("sw_upgrade_b", io.sw_upgrade_b, mdb[0][n]);
    check("sw_event", io.sw_event, mev[n]);
    check("uart_rx", io.uart_rx, mrx[n]);
    check("rstb_soc", io.rstb_soc, mrstb[n]);
`ifdef BOARD_IN_GLITCH_CNT_EN
    check("glitch_cnt", io.glitch_cnt, mgl[n]);
`endif
  end

  task automatic wait_edge(input int target);
    int guard = 0;
    while (n < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (n < target) begin
      compared++;
      mismatched++;
      $display("FAIL wait_edge: reached %0d required %0d", n, target);
    end
  endtask

  function automatic logic frame_bit(int b);
    logic [7:0] data = 8'h55;
    if (b < 0 || b > 9) return 1'b1;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return data[b-1];
  endfunction

  int c, r;

  initial begin
    io.sw_upgrade_b_raw = 1'b1;
    io.btn_rst_b_raw    = 1'b1;
    io.uart_rx_raw      = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rstb_soc", io.rstb_soc, 0);
    check("rst_sw", io.sw_upgrade_b, 1);
    check("rst_rx", io.uart_rx, 1);
    rstb_in = 1'b1;

    // Power-on stretch
    wait_edge(1);
    check("t1_rstb_e1", io.rstb_soc, 0);
    wait_edge(16);
    check("t1_rstb_e16", io.rstb_soc, 0);
    check("model_rstb_e16", mrstb[16], 0);
    wait_edge(17);
    check("t1_rstb_e17", io.rstb_soc, 1);
    check("model_rstb_e17", mrstb[17], 1);
    check("t1_sw", io.sw_upgrade_b, 1);
    check("t1_rx", io.uart_rx, 1);

    // Clean switch press and release
    wait_edge(20);
    io.sw_upgrade_b_raw = 1'b0;
    c = n + 1;
    wait_edge(c + 8);
    check("t2_sw_e9", io.sw_upgrade_b, 1);
    wait_edge(c + 9);
    check("t2_sw_e10", io.sw_upgrade_b, 0);
    check("t2_event_e10", io.sw_event, 1);
    check("model_sw_e10", mdb[0][c + 9], 0);
    wait_edge(c + 10);
    check("t2_event_e11", io.sw_event, 0);
    io.sw_upgrade_b_raw = 1'b1;
    c = n + 1;
    wait_edge(c + 9);
    check("t2_sw_back", io.sw_upgrade_b, 1);
    wait_edge(c + 12);

    // Bouncing switch never settles long enough
    for (int i = 0; i < 40; i++) begin
      io.sw_upgrade_b_raw = (((i / 3) % 2) == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      check("t3_sw_hold", io.sw_upgrade_b, 1);
      check("t3_no_event", io.sw_event, 0);
    end
    io.sw_upgrade_b_raw = 1'b1;
    repeat (12) @(negedge clk);
    check("t3_sw_end", io.sw_upgrade_b, 1);
`ifdef BOARD_IN_GLITCH_CNT_EN
    check("t3_glitch_cnt", io.glitch_cnt, 7);
    check("model_glitch_cnt", mgl[n], 7);
`endif

    // RX glitch and a 0x55 frame
    io.uart_rx_raw = 1'b0;
    @(negedge clk);
    io.uart_rx_raw = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t4_rx_glitch", io.uart_rx, 1);
    end
    for (int k = 0; k < 110; k++) begin
      io.uart_rx_raw = frame_bit(k / 10);
      check("t4_rx_frame", io.uart_rx, frame_bit((k < 4) ? -1 : (k - 4) / 10));
      @(negedge clk);
    end
    io.uart_rx_raw = 1'b1;
    repeat (5) @(negedge clk);

    // Reset button in RUN
    io.btn_rst_b_raw = 1'b0;
    c = n + 1;
    wait_edge(c + 9);
    check("t5_rstb_e10", io.rstb_soc, 1);
    wait_edge(c + 10);
    check("t5_rstb_e11", io.rstb_soc, 0);
    wait_edge(c + 19);
    io.btn_rst_b_raw = 1'b1;
    r = n + 1;
    wait_edge(r + 25);
    check("t5_rstb_pre", io.rstb_soc, 0);
    wait_edge(r + 26);
    check("t5_rstb_rise", io.rstb_soc, 1);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-debounce (cnt=5)
    io.sw_upgrade_b_raw = 1'b0;
    c = n + 1;
    wait_edge(c + 6);
    #2 rstb_in = 1'b0;
    #1;
    check("t6_async_rstb", io.rstb_soc, 0);
    check("t6_async_sw", io.sw_upgrade_b, 1);
    check("t6_async_event", io.sw_event, 0);
    check("t6_async_rx", io.uart_rx, 1);
    repeat (2) @(negedge clk);
    rstb_in = 1'b1;
    wait_edge(9);
    check("t6_sw_e9", io.sw_upgrade_b, 1);
    wait_edge(10);
    check("t6_sw_e10", io.sw_upgrade_b, 0);
    check("t6_event_e10", io.sw_event, 1);

    // Asynchronous reset mid-stretch
    wait_edge(12);
    check("t6_stretch", io.rstb_soc, 0);
    #2 rstb_in = 1'b0;
    #1;
    check("t6_async2_sw", io.sw_upgrade_b, 1);
    check("t6_async2_rstb", io.rstb_soc, 0);
    repeat (2) @(negedge clk);
    rstb_in = 1'b1;
    wait_edge(9);
    check("t6b_sw_e9", io.sw_upgrade_b, 1);
    wait_edge(10);
    check("t6b_sw_e10", io.sw_upgrade_b, 0);
    wait_edge(16);
    check("t6b_rstb_e16", io.rstb_soc, 0);
    wait_edge(17);
    check("t6b_rstb_e17", io.rstb_soc, 1);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
